// File: rtl/div_unit_pkg.sv
// Shared RV32M divide definitions: funct3 encodings for DIV/DIVU/REM/REMU,
// the MULDIV funct7 encoding and the divider FSM state type.
package div_unit_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One operation in flight at a time, one quotient bit per cycle.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous active-high reset
//   start    - request; accepted in IDLE when funct3[2]=1 and kill=0
//   kill     - flush; aborts an operation in CALC or DONE
//   funct3   - 100 DIV, 101 DIVU, 110 REM, 111 REMU (sampled on accept)
//   rs1_data - dividend (sampled on accept)
//   rs2_data - divisor  (sampled on accept)
//   busy     - high while an operation is in CALC or DONE
//   done     - one-cycle pulse, result valid this cycle
//   result   - quotient or remainder, held until the next accept
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state;
  logic [CNT_W-1:0] counter;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] dvd;          // dividend shifts out, quotient shifts in
  logic [XLEN-1:0] dsr;
  logic            op_rem;
  logic            neg_q;
  logic            neg_r;
  logic            done_q;
  logic [XLEN-1:0] result_q;
  logic [XLEN-1:0] result_prev;  // restored when a DONE cycle is killed

  // Accept-time decode
  logic            accept;
  logic            sign_in;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            div_zero;
  logic            ovf;
  logic [XLEN-1:0] special_result;

  always_comb begin
    accept         = (state == IDLE) && start && funct3[2] && !kill;
    sign_in        = ~funct3[0];
    a_neg          = sign_in & rs1_data[XLEN-1];
    b_neg          = sign_in & rs2_data[XLEN-1];
    mag_a          = a_neg ? -rs1_data : rs1_data;
    mag_b          = b_neg ? -rs2_data : rs2_data;
    div_zero       = (rs2_data == '0);
    ovf            = sign_in && (rs1_data == MOST_NEG) && (rs2_data == '1);
    special_result = '0;
    if (div_zero)
      special_result = funct3[1] ? rs1_data : '1;
    else if (ovf)
      special_result = funct3[1] ? '0 : MOST_NEG;
  end

  // One restoring step
  logic [XLEN:0]   rem_shift;
  logic            take;
  logic [XLEN:0]   rem_step;
  logic [XLEN-1:0] quo_step;
  logic [XLEN-1:0] fin_result;

  always_comb begin
    rem_shift = {rem[XLEN-1:0], dvd[XLEN-1]};
    // rem[XLEN] is always 0 after a restoring step; OR-ing it in keeps the
    // compare correct by construction should that ever not hold.
    take      = rem[XLEN] | (rem_shift >= {1'b0, dsr});
    rem_step  = take ? (rem_shift - {1'b0, dsr}) : rem_shift;
    quo_step  = {dvd[XLEN-2:0], take};
    if (op_rem)
      fin_result = neg_r ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
    else
      fin_result = neg_q ? -quo_step : quo_step;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      counter     <= '0;
      rem         <= '0;
      dvd         <= '0;
      dsr         <= '0;
      op_rem      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      busy        <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_prev <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (accept) begin
            op_rem      <= funct3[1];
            result_prev <= result_q;
            busy        <= 1'b1;
            counter     <= '0;
            if (div_zero || ovf) begin
              result_q <= special_result;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              rem   <= '0;
              dvd   <= mag_a;
              dsr   <= mag_b;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            rem     <= rem_step;
            dvd     <= quo_step;
            counter <= counter + 1'b1;
            if (counter == CNT_W'(XLEN-1)) begin
              result_q <= fin_result;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
          if (kill)
            result_q <= result_prev;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // done is registered but masked by kill in the same cycle so a flushed
  // operation never reports completion.
  assign done   = done_q & ~kill;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .kill     (kill),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // Reference model: RISC-V division semantics in plain arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int  sa;
    int  sb;
    bit  is_signed;
    bit  is_rem;
    is_signed = !f3[0];
    is_rem    = f3[1];
    sa = $signed(a);
    sb = $signed(b);
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and wait (bounded) for done; leaves the bench in the done cycle.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    bit ok;
    funct3 = f3; rs1_data = a; rs2_data = b; start = 1'b1;
    step();
    start = 1'b0;
    lat = 1;
    ok = 1'b0;
    while (lat < 100 && !ok) begin
      if (done === 1'b1) ok = 1'b1;
      else begin
        step();
        lat++;
      end
    end
    res = result;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL timeout f3=%b a=%h b=%h: no done within %0d cycles", f3, a, b, lat);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0; funct3 = 3'b000; rs1_data = '0; rs2_data = '0;
    step(); step();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", result); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_timing(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    funct3 = f3; rs1_data = a; rs2_data = b; start = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      step();
      start = 1'b0;
      tests++;
      if ({busy, done} !== {1'b1, (c == 33)}) begin
        fails++;
        $display("FAIL timing_c%0d busy/done got %b%b want 1%b", c, busy, done, (c == 33));
      end
    end
    tests++; if (result !== exp) begin fails++; $display("FAIL timing_result f3=%b got %h want %h", f3, result, exp); end
    step();
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL timing_c34 busy/done got %b%b want 00", busy, done); end
  endtask

  task automatic test_signed();
    logic [2:0]  f3s [3] = '{F3_DIV, F3_REM, F3_REM};
    logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
    logic [31:0] bs  [3] = '{32'd2, 32'd2, 32'hFFFF_FFFE};
    logic [31:0] ex  [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(f3s[i], as[i], bs[i], res, lat);
      tests++; if (res !== ex[i]) begin fails++; $display("FAIL signed_%0d got %h want %h", i, res, ex[i]); end
      tests++; if (lat != 33) begin fails++; $display("FAIL signed_lat_%0d got %0d want 33", i, lat); end
      step();
    end
  endtask

  task automatic test_special();
    logic [2:0]  f3s [5] = '{F3_DIVU, F3_REM, F3_DIV, F3_DIV, F3_REM};
    logic [31:0] as  [5] = '{32'd5, 32'h8000_0001, 32'd0, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] ex  [5] = '{32'hFFFF_FFFF, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0};
    logic [31:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(f3s[i], as[i], bs[i], res, lat);
      tests++; if (res !== ex[i]) begin fails++; $display("FAIL special_%0d got %h want %h", i, res, ex[i]); end
      tests++; if (lat != 1) begin fails++; $display("FAIL special_lat_%0d got %0d want 1", i, lat); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL special_busy_%0d got %b want 1", i, busy); end
      step();
      tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL special_after_%0d busy/done got %b%b want 00", i, busy, done); end
    end
  endtask

  task automatic test_ignore_start();
    int c;
    funct3 = F3_DIVU; rs1_data = 32'd1000; rs2_data = 32'd10; start = 1'b1;
    step(); start = 1'b0; c = 1;
    while (c < 5) begin step(); c++; end
    funct3 = F3_REMU; rs1_data = 32'd77; rs2_data = 32'd5; start = 1'b1;
    step(); start = 1'b0; c++;
    while (c < 100 && done !== 1'b1) begin step(); c++; end
    tests++; if (c != 33) begin fails++; $display("FAIL busy_start_lat got %0d want 33", c); end
    tests++; if (result !== 32'd100) begin fails++; $display("FAIL busy_start_result got %h want %h", result, 32'd100); end
    // start in the DONE cycle is ignored too
    funct3 = F3_DIVU; rs1_data = 32'd8; rs2_data = 32'd2; start = 1'b1;
    step(); start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL done_start_busy got %b want 0", busy); end
    step();
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL done_start_idle busy/done got %b%b want 00", busy, done); end
  endtask

  task automatic test_illegal_funct3();
    funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd3; start = 1'b1;
    step(); start = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL f3_000_busy got %b want 0", busy); end
    step();
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL f3_000_idle busy/done got %b%b want 00", busy, done); end
  endtask

  task automatic test_kill();
    logic [31:0] res;
    int lat;
    int c;
    bit early;
    run_op(F3_DIVU, 32'd21, 32'd7, res, lat);
    tests++; if (res !== 32'd3) begin fails++; $display("FAIL kill_setup got %h want 3", res); end
    step();
    // kill in CALC at cycle 10
    funct3 = F3_DIVU; rs1_data = 32'h0000_DEAD; rs2_data = 32'd3; start = 1'b1;
    step(); start = 1'b0; c = 1; early = 1'b0;
    while (c < 10) begin if (done === 1'b1) early = 1'b1; step(); c++; end
    kill = 1'b1;
    step(); kill = 1'b0;
    tests++; if (early) begin fails++; $display("FAIL kill_no_early_done got 1 want 0"); end
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL kill_c11 busy/done got %b%b want 00", busy, done); end
    tests++; if (result !== 32'd3) begin fails++; $display("FAIL kill_result got %h want 3", result); end
    // new op accepted at cycle 11 completes at cycle 44
    funct3 = F3_DIVU; rs1_data = 32'd9; rs2_data = 32'd3; start = 1'b1;
    step(); start = 1'b0; c = 12;
    while (c < 120 && done !== 1'b1) begin step(); c++; end
    tests++; if (c != 44) begin fails++; $display("FAIL kill_new_cycle got %0d want 44", c); end
    tests++; if (result !== 32'd3) begin fails++; $display("FAIL kill_new_result got %h want 3", result); end
    step();
    // kill and start together in IDLE
    funct3 = F3_DIV; rs1_data = 32'd40; rs2_data = 32'd4; start = 1'b1; kill = 1'b1;
    step(); start = 1'b0; kill = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL kill_start_idle busy got %b want 0", busy); end
    // kill in the DONE cycle: no done pulse, result restored
    run_op(F3_DIVU, 32'd50, 32'd5, res, lat);
    kill = 1'b1;
    #1;
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL kill_done_pulse got %b want 0", done); end
    step(); kill = 1'b0;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL kill_done_busy got %b want 0", busy); end
    tests++; if (result !== 32'd3) begin fails++; $display("FAIL kill_done_result got %h want 3", result); end
  endtask

  task automatic test_rst_midop();
    int c;
    funct3 = F3_REMU; rs1_data = 32'd1234; rs2_data = 32'd100; start = 1'b1;
    step(); start = 1'b0; c = 1;
    while (c < 20) begin step(); c++; end
    rst = 1'b1;
    step(); rst = 1'b0;
    tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL rst_mid busy/done got %b%b want 00", busy, done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL rst_mid_result got %h want 0", result); end
    step();
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int lat;
    int mode;
    for (int i = 0; i < 60; i++) begin
      f3 = {1'b1, 2'($urandom)};
      a = $urandom; b = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin
        a = $urandom_range(0, 1000); b = $urandom_range(1, 50);
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
      end else if (mode == 3) b = $urandom_range(1, 15);
      run_op(f3, a, b, res, lat);
      tests++;
      if (res !== ref_result(f3, a, b)) begin
        fails++; $display("FAIL rand_%0d f3=%b a=%h b=%h got %h want %h", i, f3, a, b, res, ref_result(f3, a, b));
      end
      tests++;
      if (lat != ref_latency(f3, a, b)) begin
        fails++; $display("FAIL rand_lat_%0d got %0d want %0d", i, lat, ref_latency(f3, a, b));
      end
      step();
      tests++; if ({busy, done} !== 2'b00) begin fails++; $display("FAIL rand_after_%0d busy/done got %b%b want 00", i, busy, done); end
    end
  endtask

  initial begin
    test_reset();
    test_timing(F3_DIVU, 32'd100, 32'd7, 32'd14);
    test_timing(F3_REMU, 32'd100, 32'd7, 32'd2);
    test_signed();
    test_special();
    test_ignore_start();
    test_illegal_funct3();
    test_kill();
    test_rst_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU in the execute stage, beside the combinational ALU.
- Consumes the same rs1_data/rs2_data operands the ALU sees.
- Produces a registered result one divide at a time under a start/busy/done handshake, so writeback no longer needs a single-cycle divider path.

Parameters:
XLEN, 32, operand/result width; only 32 is supported and verified.

Ports:
clk  input  1  system clock.
rst  input  1  reset; synchronous, active-high.
start  input  1  request pulse; accepted only when busy=0 and funct3[2]=1.
kill  input  1  pipeline flush; aborts an in-flight divide.
funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; sampled on accept.
rs1_data  input  32  dividend; sampled on accept.
rs2_data  input  32  divisor; sampled on accept.
busy  output  1  high while an operation is in flight (CALC or DONE).
done  output  1  single-cycle pulse; result valid this cycle.
result  output  32  quotient or remainder; held until the next accept.

Behaviour:
- Reset, all outputs and state: busy=0, done=0, result=0, state=IDLE, counter=0. rst has priority over everything.
- States are IDLE, CALC and DONE.
- IDLE:
  - start=1 with funct3[2]=0 is ignored.
  - On accept, latch op = funct3[1:0], sign_op = ~funct3[0], operands.
- Special cases, decided at accept. These go to DONE next cycle, skip CALC, latency 1.
  - Divisor == 0: DIV/DIVU give 0xFFFF_FFFF; REM/REMU give rs1_data.
  - Signed overflow (rs1 == 0x8000_0000, rs2 == 0xFFFF_FFFF, DIV/REM only): DIV gives 0x8000_0000, REM gives 0.
- Normal path:
  - On accept, load |a| and |b| (magnitudes only when signed).
  - Record neg_q = a[31]^b[31] and neg_r = a[31], both signed only.
  - counter = 0, go to CALC.
- CALC, restoring radix-2, one quotient bit per cycle for 32 cycles:
  - rem_next = {rem[31:0], dvd[31]}; dvd <<= 1.
  - If rem_next >= {1'b0, b}: subtract b and shift in quotient bit 1, else 0.
  - Remainder register is 33 bits.
  - After counter == 31, go to DONE.
- DONE (one cycle): done=1, busy=1.
  - result = op[1] ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo).
  - Next state is IDLE.
- Latency: accept at cycle 0 gives done=1 at cycle 33 (normal path) or cycle 1 (special case). Throughput is one op per 34 cycles; start in the DONE cycle is ignored.
- start while busy=1 is ignored; the in-flight operands are not disturbed.
- kill:
  - In CALC or DONE: next state IDLE, no done pulse (done forced 0 in a DONE cycle coinciding with kill), result keeps its previous value.
  - kill and start together in IDLE: start is ignored.
- Remainder sign follows the dividend and the quotient truncates toward zero, per RISC-V. Negation is two's complement mod 2^32.
- busy falls the cycle after DONE; done never asserts two consecutive cycles.

Decomposition:
- Shared package (e.g. riscv_pkg) holds:
  - funct3 constants F3_DIV=3'b100, F3_DIVU=3'b101, F3_REM=3'b110, F3_REMU=3'b111.
  - The div_state_t enum {IDLE, CALC, DONE}.
  - The MULDIV funct7 constant 7'b0000001.
- No sub-module: single-module FSM plus datapath, roughly 150-200 lines.

Test Plan:
- DIVU 100/7 (start at cycle 0) -> busy=1 cycles 1-33, done=1 only at cycle 33, result=14. Repeat with REMU -> 2.
- DIV 0xFFFF_FFF9 (-7)/2 -> 0xFFFF_FFFD (-3). REM same operands -> 0xFFFF_FFFF (-1). REM 7/0xFFFF_FFFE (-2) -> 1.
- Divide by zero:
  - DIVU 5/0 -> done at cycle 1, result 0xFFFF_FFFF.
  - REM 0x8000_0001/0 -> 0x8000_0001.
  - DIV 0/0 -> 0xFFFF_FFFF.
- Overflow: DIV 0x8000_0000/0xFFFF_FFFF -> 0x8000_0000 at cycle 1. REM same operands -> 0.
- Handshake:
  - Second start with new operands at cycle 5 is ignored; first result is unchanged at cycle 33.
  - start with funct3=3'b000 in IDLE -> busy stays 0.
- Abort:
  - kill at cycle 10 -> busy=0 at cycle 11, no done, result unchanged.
  - New DIVU 9/3 accepted at cycle 11 -> 3 at cycle 44.
  - rst at cycle 20 -> all outputs 0 next cycle.
